// File: rtl/branch_pred_sched_pkg.sv
// Shared types for the 2-bit saturating-counter branch predictor:
// counter encoding, reset value and the saturating update rule.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT     = 2'd0;
    localparam ctr_t WNT     = 2'd1;
    localparam ctr_t WT      = 2'd2;
    localparam ctr_t ST      = 2'd3;
    localparam ctr_t CTR_RST = WNT;

    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        ctr_t n;
        if (taken) begin
            n = (c == ST) ? ST : c + 2'd1;
        end else begin
            n = (c == SNT) ? SNT : c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_pred_sched_if.sv
// Fetch/resolve handshake bundle between the requesters and the
// branch predictor scheduler.
interface branch_pred_sched_if #(
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic [IDX_W-1:0] req_idx;
    logic             req_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic             mispredict;
    logic             full;
    logic             empty;

    modport master (
        output req_valid, req_idx, res_valid, res_taken,
        input  req_ready, pred_valid, pred_taken,
        input  res_ready, mispredict, full, empty
    );

    modport slave (
        input  req_valid, req_idx, res_valid, res_taken,
        output req_ready, pred_valid, pred_taken,
        output res_ready, mispredict, full, empty
    );
endinterface

// File: rtl/branch_pred_sched_fifo.sv
// In-order FIFO of in-flight predictions {idx, pbit}; the head is the
// oldest unresolved branch.
module bp_inflight_fifo #(
    parameter int IDX_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [IDX_W-1:0] i_push_idx,
    input  logic             i_push_pbit,
    input  logic             i_pop,
    output logic [IDX_W-1:0] o_head_idx,
    output logic             o_head_pbit,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W:0]   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_head_idx  = r_mem[r_rptr][IDX_W:1];
    assign o_head_pbit = r_mem[r_rptr][0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {i_push_idx, i_push_pbit};
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/branch_pred_sched.sv
// Counter table plus single-port arbitration between fetch lookups and
// execute resolutions; resolutions win the port.
module branch_pred_sched
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int DEPTH   = 4
) (
    input logic                clk,
    input logic                reset,
    branch_pred_sched_if.slave bus
);
    ctr_t             r_tab [ENTRIES];
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic             r_mispredict;
    logic             w_full;
    logic             w_empty;
    logic             w_req_ready;
    logic             w_req_fire;
    logic             w_res_fire;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_pbit;
    logic             w_rd_pbit;

    assign w_res_fire  = bus.res_valid && !w_empty;
    assign w_req_ready = !w_full && !w_res_fire;
    assign w_req_fire  = bus.req_valid && w_req_ready;
    assign w_rd_pbit   = r_tab[bus.req_idx][1];

    bp_inflight_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_req_fire),
        .i_push_idx  (bus.req_idx),
        .i_push_pbit (w_rd_pbit),
        .i_pop       (w_res_fire),
        .o_head_idx  (w_head_idx),
        .o_head_pbit (w_head_pbit),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tab[i] <= CTR_RST;
            end
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_pred_valid <= w_req_fire;
            if (w_req_fire) begin
                r_pred_taken <= w_rd_pbit;
            end
            r_mispredict <= w_res_fire && (bus.res_taken != w_head_pbit);
            if (w_res_fire) begin
                r_tab[w_head_idx] <= ctr_next(r_tab[w_head_idx], bus.res_taken);
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.res_ready  = !w_empty;
    assign bus.pred_valid = r_pred_valid;
    assign bus.pred_taken = r_pred_taken;
    assign bus.mispredict = r_mispredict;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;

endmodule
